// File: rtl/card_board_store_pkg.sv
// Shared definitions for the memory-match card board: state encoding,
// card word layout, shuffle constants and LFSR helpers.
package card_board_store_pkg;

   localparam int NUM_SLOTS = 16;
   localparam int LOC_W     = 4;
   localparam int DATA_W    = 6;
   localparam int NUM_PAIRS = 8;

   localparam int MATCHED_BIT = 5;
   localparam int FACEUP_BIT  = 4;
   localparam int ID_MSB      = 3;

   localparam logic [7:0] SEED_SUB   = 8'hA5;
   localparam logic [7:0] LFSR_RESET = 8'h01;
   // Taps q[7], q[5], q[4], q[3] realise x^8+x^6+x^5+x^4+1.
   localparam logic [7:0] LFSR_TAPS  = 8'b1011_1000;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_PICK  = 3'd2,
      ST_SWAP  = 3'd3,
      ST_READY = 3'd4
   } board_state_t;

   function automatic logic lfsr_feedback(input logic [7:0] q);
      return ^(q & LFSR_TAPS);
   endfunction

   // A zero seed would lock the LFSR, so it is substituted.
   function automatic logic [7:0] seed_value(input logic [7:0] s);
      return (s == 8'h00) ? SEED_SUB : s;
   endfunction

endpackage

// File: rtl/card_board_store_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous load (priority) and step enable.
module card_board_store_lfsr8
   import card_board_store_pkg::*;
(
   input  logic       Clk,
   input  logic       Reset,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       step,
   output logic [7:0] q
);

   logic [7:0] q_r;
   logic [7:0] q_s;

   // Next-state selection: load beats step.
   always_comb begin
      q_s = q_r;
      if (load) begin
         q_s = load_val;
      end else if (step) begin
         q_s = {q_r[6:0], lfsr_feedback(q_r)};
      end else begin
         q_s = q_r;
      end
   end

   // State register.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         q_r <= LFSR_RESET;
      end else begin
         q_r <= q_s;
      end
   end

   assign q = q_r;

endmodule

// File: rtl/card_board_store.sv
// 16-slot card board: fills 8 pairs, Fisher-Yates shuffles them with an
// LFSR, then serves cursor reads and gameplay writes.
module card_board_store
   import card_board_store_pkg::*;
(
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Init,
   input  logic [7:0]        seed,
   input  logic [LOC_W-1:0]  CursorLoc,
   output logic [DATA_W-1:0] CardSelectData,
   input  logic              WriteEnable,
   input  logic [LOC_W-1:0]  dataLoc,
   input  logic [DATA_W-1:0] dataOut,
   output logic              Busy,
   output logic              Ready,
   output logic              AllMatched
);

   board_state_t      state_r, state_s;
   logic [DATA_W-1:0] slot_r [NUM_SLOTS];
   logic [DATA_W-1:0] slot_s [NUM_SLOTS];
   logic [LOC_W-1:0]  idx_r, idx_s;
   logic [LOC_W-1:0]  pick_r, pick_s;
   logic [LOC_W-1:0]  cand_s;
   logic [DATA_W-1:0] card_r;
   logic              busy_r, ready_r, all_r;
   logic              busy_next_s;
   logic              all_s;
   logic              lfsr_load_s, lfsr_step_s;
   logic [7:0]        lfsr_q;

   card_board_store_lfsr8 u_lfsr (
      .Clk      (Clk),
      .Reset    (Reset),
      .load     (lfsr_load_s),
      .load_val (seed_value(seed)),
      .step     (lfsr_step_s),
      .q        (lfsr_q)
   );

   assign cand_s = lfsr_q[LOC_W-1:0];

   // Board FSM next state and post-update array.
   always_comb begin
      state_s     = state_r;
      idx_s       = idx_r;
      pick_s      = pick_r;
      slot_s      = slot_r;
      lfsr_load_s = 1'b0;
      lfsr_step_s = 1'b0;
      if (Init) begin
         lfsr_load_s = 1'b1;
         state_s     = ST_FILL;
      end else begin
         case (state_r)
            ST_IDLE, ST_READY: begin
               if (WriteEnable) begin
                  slot_s[dataLoc] = dataOut;
               end else begin
                  slot_s = slot_r;
               end
            end
            ST_FILL: begin
               for (int k = 0; k < NUM_SLOTS; k++) begin
                  slot_s[k] = DATA_W'(k / 2);
               end
               idx_s   = 4'd15;
               state_s = ST_PICK;
            end
            ST_PICK: begin
               lfsr_step_s = 1'b1;
               // Rejection sampling keeps the shuffle unbiased over 0..i.
               if (cand_s <= idx_r) begin
                  pick_s  = cand_s;
                  state_s = ST_SWAP;
               end else begin
                  state_s = ST_PICK;
               end
            end
            ST_SWAP: begin
               slot_s[idx_r]  = slot_r[pick_r];
               slot_s[pick_r] = slot_r[idx_r];
               if (idx_r == 4'd1) begin
                  state_s = ST_READY;
               end else begin
                  idx_s   = idx_r - 4'd1;
                  state_s = ST_PICK;
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
   end

   // Busy flag for the state being entered.
   always_comb begin
      case (state_s)
         ST_FILL, ST_PICK, ST_SWAP: busy_next_s = 1'b1;
         default:                   busy_next_s = 1'b0;
      endcase
   end

   // Match reduction over the post-update array.
   always_comb begin
      all_s = 1'b1;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         all_s = all_s & slot_s[k][MATCHED_BIT];
      end
   end

   // Board state, array and registered outputs.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_r <= ST_IDLE;
         for (int k = 0; k < NUM_SLOTS; k++) begin
            slot_r[k] <= 6'h00;
         end
         idx_r   <= 4'd0;
         pick_r  <= 4'd0;
         card_r  <= 6'h00;
         busy_r  <= 1'b0;
         ready_r <= 1'b0;
         all_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         for (int k = 0; k < NUM_SLOTS; k++) begin
            slot_r[k] <= slot_s[k];
         end
         idx_r   <= idx_s;
         pick_r  <= pick_s;
         card_r  <= slot_s[CursorLoc];
         busy_r  <= busy_next_s;
         ready_r <= (state_s == ST_READY);
         all_r   <= all_s & ~busy_next_s;
      end
   end

   assign CardSelectData = card_r;
   assign Busy           = busy_r;
   assign Ready          = ready_r;
   assign AllMatched     = all_r;

endmodule
